// File: rtl/reg_commit_queue.sv
// Commit queue between the ROB and the register file write port: in-order drain
// that pauses on misbranch, with youngest-match forwarding of still-queued values.
module reg_commit_queue #(
    parameter int DEPTH         = 4,
    parameter int REG_TAG_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int ROB_TAG_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     in_rob_valid,
    input  logic [REG_TAG_WIDTH-1:0] in_rob_index,
    input  logic [DATA_WIDTH-1:0]    in_rob_value,
    input  logic [ROB_TAG_WIDTH-1:0] in_rob_reorder,
    output logic                     out_rob_full,
    input  logic                     in_reg_misbranch,
    output logic [REG_TAG_WIDTH-1:0] out_reg_index,
    output logic [DATA_WIDTH-1:0]    out_reg_value,
    output logic [ROB_TAG_WIDTH-1:0] out_reg_reorder,
    input  logic [REG_TAG_WIDTH-1:0] in_decode_rs1,
    input  logic [REG_TAG_WIDTH-1:0] in_decode_rs2,
    output logic                     out_fwd_rs1_hit,
    output logic                     out_fwd_rs2_hit,
    output logic [DATA_WIDTH-1:0]    out_fwd_rs1_value,
    output logic [DATA_WIDTH-1:0]    out_fwd_rs2_value
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [REG_TAG_WIDTH-1:0] idx_q [DEPTH];
    logic [DATA_WIDTH-1:0]    val_q [DEPTH];
    logic [ROB_TAG_WIDTH-1:0] tag_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic enq_s;
    logic deq_s;

    // Handshake decode and next-state pointer/count arithmetic
    always_comb begin
        enq_s   = rdy & in_rob_valid & (count_q != FULL_CNT) &
                  (in_rob_index != {REG_TAG_WIDTH{1'b0}});
        deq_s   = rdy & ~in_reg_misbranch & (count_q != {CNT_W{1'b0}});
        head_d  = deq_s ? head_q + PTR_W'(1) : head_q;
        tail_d  = enq_s ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(enq_s) - CNT_W'(deq_s);
    end

    // Queue storage and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= {REG_TAG_WIDTH{1'b0}};
                val_q[i] <= {DATA_WIDTH{1'b0}};
                tag_q[i] <= {ROB_TAG_WIDTH{1'b0}};
            end
        end else begin
            if (enq_s) begin
                idx_q[tail_q] <= in_rob_index;
                val_q[tail_q] <= in_rob_value;
                tag_q[tail_q] <= in_rob_reorder;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Register-file write port and full flag
    always_comb begin
        out_rob_full    = (count_q == FULL_CNT);
        out_reg_index   = deq_s ? idx_q[head_q] : {REG_TAG_WIDTH{1'b0}};
        out_reg_value   = deq_s ? val_q[head_q] : {DATA_WIDTH{1'b0}};
        out_reg_reorder = deq_s ? tag_q[head_q] : {ROB_TAG_WIDTH{1'b0}};
    end

    logic [PTR_W-1:0] pos_s;
    logic             m1_s;
    logic             m2_s;

    // Walk from oldest to youngest so the last match seen wins
    always_comb begin
        out_fwd_rs1_hit   = 1'b0;
        out_fwd_rs2_hit   = 1'b0;
        out_fwd_rs1_value = {DATA_WIDTH{1'b0}};
        out_fwd_rs2_value = {DATA_WIDTH{1'b0}};
        pos_s             = {PTR_W{1'b0}};
        m1_s              = 1'b0;
        m2_s              = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            pos_s = head_q + PTR_W'(k);
            m1_s  = (CNT_W'(k) < count_q) & (in_decode_rs1 != {REG_TAG_WIDTH{1'b0}}) &
                    (idx_q[pos_s] == in_decode_rs1);
            m2_s  = (CNT_W'(k) < count_q) & (in_decode_rs2 != {REG_TAG_WIDTH{1'b0}}) &
                    (idx_q[pos_s] == in_decode_rs2);
            out_fwd_rs1_hit   = out_fwd_rs1_hit | m1_s;
            out_fwd_rs2_hit   = out_fwd_rs2_hit | m2_s;
            out_fwd_rs1_value = m1_s ? val_q[pos_s] : out_fwd_rs1_value;
            out_fwd_rs2_value = m2_s ? val_q[pos_s] : out_fwd_rs2_value;
        end
    end

endmodule

// File: tb/tb_reg_commit_queue.sv
// Scoreboard bench for reg_commit_queue: the driver pushes accepted commits, a
// negedge monitor pops and compares every register-file write slot.
module tb_reg_commit_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] val;
        logic [3:0]  tag;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        in_rob_valid = 1'b0;
    logic [4:0]  in_rob_index = 5'd0;
    logic [31:0] in_rob_value = 32'd0;
    logic [3:0]  in_rob_reorder = 4'd0;
    logic        out_rob_full;
    logic        in_reg_misbranch = 1'b0;
    logic [4:0]  out_reg_index;
    logic [31:0] out_reg_value;
    logic [3:0]  out_reg_reorder;
    logic [4:0]  in_decode_rs1 = 5'd0;
    logic [4:0]  in_decode_rs2 = 5'd0;
    logic        out_fwd_rs1_hit, out_fwd_rs2_hit;
    logic [31:0] out_fwd_rs1_value, out_fwd_rs2_value;

    ent_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   acc;
    int   tries;

    reg_commit_queue #(.DEPTH(DEPTH), .REG_TAG_WIDTH(5), .DATA_WIDTH(32), .ROB_TAG_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_rob_valid(in_rob_valid), .in_rob_index(in_rob_index),
        .in_rob_value(in_rob_value), .in_rob_reorder(in_rob_reorder),
        .out_rob_full(out_rob_full), .in_reg_misbranch(in_reg_misbranch),
        .out_reg_index(out_reg_index), .out_reg_value(out_reg_value),
        .out_reg_reorder(out_reg_reorder),
        .in_decode_rs1(in_decode_rs1), .in_decode_rs2(in_decode_rs2),
        .out_fwd_rs1_hit(out_fwd_rs1_hit), .out_fwd_rs2_hit(out_fwd_rs2_hit),
        .out_fwd_rs1_value(out_fwd_rs1_value), .out_fwd_rs2_value(out_fwd_rs2_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; entered and left 1 time unit after a rising edge
    task automatic cyc(input logic v, input logic [4:0] idx, input logic [31:0] val,
                       input logic [3:0] tag, input logic misb, input logic r, output bit a);
        ent_t e;
        in_rob_valid = v; in_rob_index = idx; in_rob_value = val; in_rob_reorder = tag;
        in_reg_misbranch = misb; rdy = r;
        a = r && v && (idx != 5'd0) && (sb.size() != DEPTH);
        e.idx = idx; e.val = val; e.tag = tag;
        @(posedge clk);
        if (a) sb.push_back(e);
        #1;
    endtask

    task automatic idle(input int n, input logic misb);
        bit a;
        for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 32'd0, 4'd0, misb, 1'b1, a);
    endtask

    // Monitor: the write slot must carry the scoreboard head exactly when a drain is due
    initial begin
        ent_t e;
        bit   exp_deq;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_deq = rdy && !in_reg_misbranch && (sb.size() != 0);
                chk("rob_full", {31'd0, out_rob_full}, {31'd0, sb.size() == DEPTH});
                if (exp_deq) begin
                    e = sb[0];
                    chk("wr_index", {27'd0, out_reg_index}, {27'd0, e.idx});
                    chk("wr_value", out_reg_value, e.val);
                    chk("wr_reorder", {28'd0, out_reg_reorder}, {28'd0, e.tag});
                    sb.pop_front();
                end else begin
                    chk("idle_index", {27'd0, out_reg_index}, 32'd0);
                    chk("idle_value", out_reg_value, 32'd0);
                    chk("idle_reorder", {28'd0, out_reg_reorder}, 32'd0);
                end
            end
        end
    end

    initial begin
        #2;
        chk("rst_full", {31'd0, out_rob_full}, 32'd0);
        chk("rst_index", {27'd0, out_reg_index}, 32'd0);
        chk("rst_count", {28'd0, dut.count_q}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // basic drain
        cyc(1'b1, 5'd5, 32'h11, 4'd3, 1'b0, 1'b1, acc);
        idle(2, 1'b0);
        chk("basic_count", {28'd0, dut.count_q}, 32'd0);

        // x0 discard
        cyc(1'b1, 5'd0, 32'hFF, 4'd1, 1'b0, 1'b1, acc);
        idle(1, 1'b0);
        chk("x0_count", {28'd0, dut.count_q}, 32'd0);

        // misbranch hold, then in-order drain
        cyc(1'b1, 5'd9, 32'h21, 4'd1, 1'b1, 1'b1, acc);
        cyc(1'b1, 5'd10, 32'h22, 4'd2, 1'b1, 1'b1, acc);
        idle(1, 1'b1);
        chk("misb_count", {28'd0, dut.count_q}, 32'd2);
        // rdy low: refused commit, frozen queue, forwarding still valid
        in_decode_rs1 = 5'd10;
        cyc(1'b1, 5'd11, 32'h33, 4'd4, 1'b0, 1'b0, acc);
        chk("rdy_fwd_hit", {31'd0, out_fwd_rs1_hit}, 32'd1);
        chk("rdy_fwd_val", out_fwd_rs1_value, 32'h22);
        chk("rdy_count", {28'd0, dut.count_q}, 32'd2);
        idle(3, 1'b0);

        // fill to full under misbranch, 5th held until a slot frees
        for (int i = 1; i <= 4; i++)
            cyc(1'b1, 5'(i + 15), 32'h100 + 32'(i), 4'(i), 1'b1, 1'b1, acc);
        chk("full_after4", {31'd0, out_rob_full}, 32'd1);
        cyc(1'b1, 5'd20, 32'h105, 4'd5, 1'b1, 1'b1, acc);
        chk("fifth_refused_misb", {31'd0, acc}, 32'd0);
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 10) begin
            cyc(1'b1, 5'd20, 32'h105, 4'd5, 1'b0, 1'b1, acc);
            tries++;
        end
        chk("fifth_accepted", {31'd0, acc}, 32'd1);
        chk("fifth_wait_cycles", 32'(tries), 32'd2);
        idle(6, 1'b0);

        // forwarding: youngest match wins, new arrival not visible
        cyc(1'b1, 5'd7, 32'hA, 4'd1, 1'b1, 1'b1, acc);
        in_decode_rs1 = 5'd7; in_decode_rs2 = 5'd0;
        #1;
        chk("fwd_one_val", out_fwd_rs1_value, 32'hA);
        cyc(1'b1, 5'd7, 32'hB, 4'd2, 1'b1, 1'b1, acc);
        chk("fwd_rs1_hit", {31'd0, out_fwd_rs1_hit}, 32'd1);
        chk("fwd_rs1_val", out_fwd_rs1_value, 32'hB);
        chk("fwd_rs2_hit", {31'd0, out_fwd_rs2_hit}, 32'd0);
        chk("fwd_rs2_val", out_fwd_rs2_value, 32'd0);
        in_rob_valid = 1'b1; in_rob_index = 5'd12; in_rob_value = 32'hC; in_decode_rs2 = 5'd12;
        #1;
        chk("fwd_arrival_miss", {31'd0, out_fwd_rs2_hit}, 32'd0);
        in_rob_valid = 1'b0; in_decode_rs2 = 5'd0;
        idle(4, 1'b0);
        chk("fwd_drained_hit", {31'd0, out_fwd_rs1_hit}, 32'd0);

        // async reset with 3 entries queued, mid-drain
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 5'(i + 2), 32'h200 + 32'(i), 4'(i + 8), 1'b1, 1'b1, acc);
        in_reg_misbranch = 1'b0; in_rob_valid = 1'b0; in_decode_rs1 = 5'd2;
        #1;
        chk("pre_rst_index", {27'd0, out_reg_index}, 32'd2);
        rst = 1'b1;
        #1;
        chk("arst_count", {28'd0, dut.count_q}, 32'd0);
        chk("arst_index", {27'd0, out_reg_index}, 32'd0);
        chk("arst_full", {31'd0, out_rob_full}, 32'd0);
        chk("arst_fwd", {31'd0, out_fwd_rs1_hit}, 32'd0);
        sb.delete();
        rst = 1'b0;
        idle(3, 1'b0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_commit_queue.md
# reg_commit_queue

Buffers architectural results retired by the ROB and drains them, one per cycle, into the register file's single write port (index/value/reorder). Commits are never lost across a misbranch: drain pauses during the flush cycle and resumes afterwards. The block also provides youngest-match forwarding to decode for registers whose committed value is still queued. It sits between the ROB commit stage and `register`.

## Interface
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high. Clears all state.
- `rdy` input 1: global ready. When low, nothing changes and no write is issued.
- `in_rob_valid` input 1: ROB presents a commit this cycle.
- `in_rob_index` input `REG_TAG_WIDTH` (5): destination register.
- `in_rob_value` input `DATA_WIDTH` (32): result.
- `in_rob_reorder` input `ROB_TAG_WIDTH`: ROB tag of the committing instruction.
- `out_rob_full` output 1: queue full; ROB must hold its commit.
- `in_reg_misbranch` input 1: flush cycle. Register file ignores writes.
- `out_reg_index` output `REG_TAG_WIDTH`: write index; 0 means no write.
- `out_reg_value` output `DATA_WIDTH`: write data.
- `out_reg_reorder` output `ROB_TAG_WIDTH`: tag used by the register file to clear its reorder entry.
- `in_decode_rs1`, `in_decode_rs2` input `REG_TAG_WIDTH` each: source registers being renamed.
- `out_fwd_rs1_hit`, `out_fwd_rs2_hit` output 1 each: a queued entry matches that source.
- `out_fwd_rs1_value`, `out_fwd_rs2_value` output `DATA_WIDTH` each: value of the youngest matching entry; 0 on miss.

## Operation
- **Storage.** Circular buffer of {index, value, reorder}.
  - Pointers `head` and `tail`, each log2(DEPTH) bits, wrap modulo DEPTH.
  - `count` is 0..DEPTH and is log2(DEPTH)+1 bits wide.
- **Enqueue** (`enq`) = `rdy` & `in_rob_valid` & (`count` != DEPTH) & (`in_rob_index` != 0).
  - Writes the entry at `tail`; `tail`++.
  - Commits to x0 are accepted silently and discarded; they never occupy an entry.
- **Full rule.** `out_rob_full` = (`count` == DEPTH), combinational from `count`.
  - When full, an enqueue is refused even if a pop happens in the same cycle.
  - The ROB must keep `in_rob_valid` and its data stable until `out_rob_full` is low.
- **Drain** (`deq`) = `rdy` & !`in_reg_misbranch` & (`count` != 0).
  - While `deq` is high, `out_reg_*` show the entry at `head` combinationally.
  - At the clock edge the register file latches the entry and `head`++.
  - When `deq` is low, `out_reg_index`, `out_reg_value` and `out_reg_reorder` are all 0.
- **Count update.** `count` += `enq` − `deq`. Simultaneous enq and deq leaves `count` unchanged.
- **Misbranch.** Queue contents are preserved; those instructions are already architecturally committed.
  - Only the drain pauses. Enqueue follows the normal rule.
- **Forwarding** (combinational), per source:
  - Hit when rs != 0 and some valid entry has index == rs.
  - The value comes from the youngest matching entry, i.e. the one closest to `tail`.
  - The head entry being written in the current cycle still counts as a hit.
  - A commit arriving this cycle is not forwarded; it is visible the cycle after enqueue.
- **No state machine beyond the FIFO.** Order is strictly preserved. Repeated writes to the same register drain in commit order.

## Timing
- **Reset** (async, `rst` high):
  - `head` = `tail` = `count` = 0, all entries cleared.
  - `out_rob_full` = 0, `out_reg_*` = 0, `out_fwd_*` = 0.
  - Reset asserted mid-drain drops all queued entries immediately.
- **Latency.** A commit accepted at edge t appears on `out_reg_*` in the cycle after t, provided `rdy` is high and misbranch is low. The register file updates at the following edge, t+1.
- **Throughput.** One enqueue and one drain per cycle. A continuous 1/cycle stream runs with `count` fixed at 1.
- **`rdy` low.** Pointers and `count` frozen; `out_reg_index` = 0; forwarding outputs stay valid.
- **Wrap-around.** Pointers wrap DEPTH−1 → 0 with no bubble.
- **Full.** Reached after DEPTH enqueues without a drain, e.g. during a misbranch burst. `out_rob_full` falls the cycle after the first drain edge.

## Test plan
- **Basic drain.** Reset, then commit (x5, 0x11, tag 3) at edge 1 → cycle 2: `out_reg_index`=5, `out_reg_value`=0x11, `out_reg_reorder`=3. Cycle 3: index 0, `count`=0.
- **x0 discard.** Commit (x0, 0xFF) → `count` stays 0, `out_reg_index` stays 0, `out_rob_full` never rises.
- **Misbranch hold.** Queue 2 entries while `in_reg_misbranch` is high for 3 cycles → `out_reg_index`=0 throughout. The first entry appears the cycle misbranch drops and both drain in order.
- **Full and back-pressure.** With DEPTH=4, hold misbranch and issue 5 commits → `out_rob_full`=1 after the 4th. The 5th is held until the first drain and then accepted. Drain order is 1..5, including pointer wrap.
- **Forwarding.** Queue (x7, 0xA) then (x7, 0xB) with drain blocked; `in_decode_rs1`=7 → hit=1, value=0xB. `in_decode_rs2`=0 → hit=0. After both drain → rs1 hit=0.
- **Async reset.** Pulse `rst` mid-cycle with 3 entries queued → `count`=0, `out_reg_index`=0 and `out_rob_full`=0 immediately, without waiting for a clock edge.
